// File: rtl/wb_mem_responder.sv
// Wishbone responder backed by a local word memory: byte-lane writes, fixed wait
// states, periodic retry injection, out-of-range error, doorbell interrupt, ack counter.
module wb_mem_responder #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 16,
    parameter int                       DEPTH         = 256,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       WAIT_STATES   = 0,
    parameter int                       RTY_PERIOD    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cyc,
    input  logic                         stb,
    input  logic [WB_ADDR_WIDTH-1:0]     adr,
    input  logic                         we,
    input  logic [WB_DATA_WIDTH-1:0]     dout,
    input  logic [WB_DATA_WIDTH/8-1:0]   sel,
    output logic [WB_DATA_WIDTH-1:0]     din,
    output logic                         ack,
    output logic                         err,
    output logic                         rty,
    output logic                         inta,
    output logic                         busy,
    output logic [15:0]                  xfer_count
);
    localparam int NB = WB_DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH);
    // One extra bit so BASE_ADDR+DEPTH cannot wrap back into the address space.
    localparam logic [WB_ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (WB_ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                     state, nstate;
    logic [3:0]                 wcnt;
    logic [31:0]                rcnt;
    logic [IW-1:0]              a_idx;
    logic                       a_inr, a_we, a_rty;
    logic [NB-1:0]              a_sel;
    logic [WB_DATA_WIDTH-1:0]   a_dout;
    logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];
    logic [WB_DATA_WIDTH-1:0]   wr_word;
    logic [IW-1:0]              idx;
    logic                       in_range, accept;
    logic                       do_ack, do_err, do_rty;

    assign idx      = IW'(adr - BASE_ADDR);
    assign in_range = (adr >= BASE_ADDR) && ({1'b0, adr} < LIMIT);
    assign accept   = (state == S_IDLE) && cyc && stb;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (cyc && stb) nstate = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (!cyc) nstate = S_IDLE;
                     else if (wcnt == 4'd1) nstate = S_RESP;
            S_RESP:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        do_ack = 1'b0;
        do_err = 1'b0;
        do_rty = 1'b0;
        if (state == S_RESP) begin
            if (!a_inr)     do_err = 1'b1;
            else if (a_rty) do_rty = 1'b1;
            else            do_ack = 1'b1;
        end
    end

    always_comb begin
        wr_word = mem[a_idx];
        for (int i = 0; i < NB; i++)
            if (a_sel[i]) wr_word[8*i +: 8] = a_dout[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack        <= 1'b0;
            err        <= 1'b0;
            rty        <= 1'b0;
            din        <= '0;
            inta       <= 1'b0;
            busy       <= 1'b0;
            xfer_count <= '0;
            rcnt       <= '0;
            wcnt       <= '0;
            a_idx      <= '0;
            a_inr      <= 1'b0;
            a_we       <= 1'b0;
            a_rty      <= 1'b0;
            a_sel      <= '0;
            a_dout     <= '0;
        end else begin
            ack  <= do_ack;
            err  <= do_err;
            rty  <= do_rty;
            din  <= (do_ack && !a_we) ? mem[a_idx] : '0;
            busy <= (nstate != S_IDLE);
            if (accept) begin
                a_idx  <= idx;
                a_inr  <= in_range;
                a_we   <= we;
                a_sel  <= sel;
                a_dout <= dout;
                wcnt   <= 4'(WAIT_STATES);
                a_rty  <= 1'b0;
                // Retry decision is made at accept; the period restarts on the rty'd request.
                if (in_range && RTY_PERIOD > 0) begin
                    if (rcnt == 32'(RTY_PERIOD - 1)) begin
                        a_rty <= 1'b1;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + 32'd1;
                    end
                end
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            if (do_ack && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
            if (do_ack && a_idx == IW'(DEPTH - 1)) inta <= a_we ? (wr_word != '0) : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_ack && a_we) mem[a_idx] <= wr_word;
    end
endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: four differently parameterised instances driven by
// directed steps and random traffic, checked against a transaction-level model.
module tb_wb_mem_responder;
    localparam int          N     = 4;
    localparam int          DEPTH = 256;
    localparam int          WS_P   [N] = '{0, 3, 0, 0};
    localparam logic [31:0] BASE_P [N] = '{32'h0, 32'h0, 32'h100, 32'h0};
    localparam int          RTY_P  [N] = '{0, 0, 0, 3};

    logic             clk = 1'b0;
    logic [N-1:0]     rst, cyc, stb, we, ack, err, rty, inta, busy;
    logic [31:0]      adr  [N];
    logic [15:0]      dout [N];
    logic [15:0]      din  [N];
    logic [15:0]      xc   [N];
    logic [1:0]       sel  [N];

    int checks = 0;
    int errors = 0;

    // Transaction-level model: word store keyed by instance and offset.
    logic [15:0] m_mem [int unsigned];
    int          m_xc   [N];
    bit          m_inta [N];
    int          m_acc  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_mem_responder #(
            .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16), .DEPTH(DEPTH), .BASE_ADDR(BASE_P[g]),
            .WAIT_STATES(WS_P[g]), .RTY_PERIOD(RTY_P[g])
        ) u_dut (
            .clk(clk), .rst(rst[g]), .cyc(cyc[g]), .stb(stb[g]), .adr(adr[g]), .we(we[g]),
            .dout(dout[g]), .sel(sel[g]), .din(din[g]), .ack(ack[g]), .err(err[g]),
            .rty(rty[g]), .inta(inta[g]), .busy(busy[g]), .xfer_count(xc[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // term is {ack,err,rty}
    task automatic xact(input int k, input bit w, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] s, output logic [2:0] term, output logic [15:0] rd);
        logic [31:0] off;
        logic [2:0]  expt;
        logic [15:0] expd, word;
        bit          inr, known;
        int          lat;
        int unsigned key;
        off   = a - BASE_P[k];
        inr   = (a >= BASE_P[k]) && (off < DEPTH);
        expt  = 3'b010;
        expd  = '0;
        known = 1'b1;
        if (inr) begin
            m_acc[k]++;
            key = k * 1024 + off;
            if (RTY_P[k] > 0 && m_acc[k] % RTY_P[k] == 0) expt = 3'b001;
            else begin
                expt = 3'b100;
                if (m_xc[k] < 16'hFFFF) m_xc[k]++;
                if (w) begin
                    word = m_mem.exists(key) ? m_mem[key] : 16'h0;
                    for (int i = 0; i < 2; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
                    m_mem[key] = word;
                    if (off == DEPTH - 1) m_inta[k] = (word != 16'h0);
                end else begin
                    known = m_mem.exists(key);
                    if (known) expd = m_mem[key];
                    if (off == DEPTH - 1) m_inta[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dout[k] = d; sel[k] = s;
        @(posedge clk);
        lat = 0;
        while (1) begin
            @(negedge clk);
            term = {ack[k], err[k], rty[k]};
            if (term != 3'b000 || lat > 40) break;
            chk($sformatf("k%0d busy lat%0d", k, lat), {31'b0, busy[k]}, 32'd1);
            @(posedge clk);
            lat++;
        end
        rd = din[k];
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        chk($sformatf("k%0d term a=%0h", k, a), {29'b0, term}, {29'b0, expt});
        chk($sformatf("k%0d latency", k), lat, WS_P[k] + 1);
        if (known) chk($sformatf("k%0d din a=%0h", k, a), {16'b0, rd}, {16'b0, expd});
        @(negedge clk);
        chk($sformatf("k%0d one-cycle term", k), {28'b0, ack[k], err[k], rty[k], busy[k]}, 32'd0);
        chk($sformatf("k%0d xfer_count", k), {16'b0, xc[k]}, m_xc[k]);
        chk($sformatf("k%0d inta", k), {31'b0, inta[k]}, {31'b0, m_inta[k]});
    endtask

    task automatic abort_req(input int k, input logic [31:0] a, input logic [15:0] d);
        bit seen;
        m_acc[k]++;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = a; dout[k] = d; sel[k] = 2'b11;
        @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack[k] | err[k] | rty[k]) seen = 1'b1;
        end
        chk($sformatf("k%0d abort term", k), {31'b0, seen}, 32'd0);
        chk($sformatf("k%0d abort busy", k), {31'b0, busy[k]}, 32'd0);
        chk($sformatf("k%0d abort xfer_count", k), {16'b0, xc[k]}, m_xc[k]);
    endtask

    logic [2:0]  t;
    logic [15:0] rd;
    logic [2:0]  seq [5];

    initial begin
        rst = '0; cyc = '0; stb = '0; we = '0;
        for (int i = 0; i < N; i++) begin
            adr[i] = '0; dout[i] = '0; sel[i] = '0;
            m_xc[i] = 0; m_inta[i] = 1'b0; m_acc[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("k%0d reset", i), {ack[i], err[i], rty[i], inta[i], busy[i], din[i], xc[i]}, 32'd0);
        rst = '1;

        // Basic write then read, no wait states.
        xact(0, 1, 32'd5, 16'hA55A, 2'b11, t, rd);
        xact(0, 0, 32'd5, 16'h0000, 2'b11, t, rd);
        chk("default read", {16'b0, rd}, 32'h0000A55A);
        chk("default count", {16'b0, xc[0]}, 32'd2);

        // Byte lanes.
        xact(0, 1, 32'd7, 16'h1234, 2'b11, t, rd);
        xact(0, 1, 32'd7, 16'hABCD, 2'b01, t, rd);
        xact(0, 0, 32'd7, 16'h0000, 2'b00, t, rd);
        chk("byte lanes", {16'b0, rd}, 32'h000012CD);

        // Doorbell set/clear, including write of zero.
        xact(0, 1, 32'd255, 16'h0001, 2'b11, t, rd);
        chk("doorbell set", {31'b0, inta[0]}, 32'd1);
        xact(0, 0, 32'd255, 16'h0000, 2'b11, t, rd);
        chk("doorbell read clr", {31'b0, inta[0]}, 32'd0);
        xact(0, 1, 32'd255, 16'h0100, 2'b10, t, rd);
        xact(0, 1, 32'd255, 16'h0000, 2'b11, t, rd);
        chk("doorbell zero clr", {31'b0, inta[0]}, 32'd0);

        // Wait states and abort.
        xact(1, 1, 32'd0, 16'h5AA5, 2'b11, t, rd);
        xact(1, 0, 32'd0, 16'h0000, 2'b11, t, rd);
        abort_req(1, 32'd0, 16'hFFFF);
        xact(1, 0, 32'd0, 16'h0000, 2'b11, t, rd);
        chk("abort no write", {16'b0, rd}, 32'h00005AA5);

        // Reset mid-WAIT cancels everything but memory.
        xact(1, 1, 32'd3, 16'h3C3C, 2'b11, t, rd);
        xact(1, 1, 32'd255, 16'h8000, 2'b11, t, rd);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd3; dout[1] = 16'hDEAD; sel[1] = 2'b11;
        @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid-wait reset", {ack[1], err[1], rty[1], inta[1], busy[1], din[1], xc[1]}, 32'd0);
        rst[1] = 1'b1;
        m_xc[1] = 0; m_inta[1] = 1'b0; m_acc[1] = 0;
        xact(1, 0, 32'd3, 16'h0000, 2'b11, t, rd);
        chk("reset no write", {16'b0, rd}, 32'h00003C3C);

        // Address range with nonzero base.
        xact(2, 1, 32'h0FF, 16'h1111, 2'b11, t, rd);
        chk("below base", {29'b0, t}, 32'd2);
        xact(2, 1, 32'h200, 16'h2222, 2'b11, t, rd);
        chk("above top", {29'b0, t}, 32'd2);
        chk("err no count", {16'b0, xc[2]}, 32'd0);
        xact(2, 1, 32'h100, 16'h3333, 2'b11, t, rd);
        chk("base ack", {29'b0, t}, 32'd4);

        // Retry every third in-range request.
        for (int i = 0; i < 5; i++) begin
            xact(3, 0, 32'd1 + i, 16'h0000, 2'b11, t, rd);
            seq[i] = t;
        end
        chk("rty pattern", {17'b0, seq[0], seq[1], seq[2], seq[3], seq[4]}, {17'b0, 15'b100_100_001_100_100});
        chk("rty count", {16'b0, xc[3]}, 32'd4);
        xact(3, 1, 32'd9, 16'h1111, 2'b11, t, rd);
        chk("rty write", {29'b0, t}, 32'd1);
        xact(3, 1, 32'd9, 16'h2222, 2'b11, t, rd);
        xact(3, 1, 32'd9, 16'h3333, 2'b11, t, rd);
        xact(3, 1, 32'd9, 16'h4444, 2'b11, t, rd);
        xact(3, 0, 32'd9, 16'h0000, 2'b11, t, rd);
        chk("rty no write", {16'b0, rd}, 32'h00003333);

        // Random traffic across all instances.
        for (int n = 0; n < 300; n++) begin
            int          k, r;
            logic [31:0] a;
            bit          w;
            logic [15:0] d;
            logic [1:0]  s;
            int unsigned key;
            k = $urandom_range(0, N - 1);
            r = $urandom_range(0, 9);
            if (r <= 5)                        a = BASE_P[k] + $urandom_range(0, 15);
            else if (r <= 7)                   a = BASE_P[k] + DEPTH - 1;
            else if (r == 8 || BASE_P[k] == 0) a = BASE_P[k] + DEPTH + $urandom_range(0, 1000);
            else                               a = BASE_P[k] - 1 - $urandom_range(0, 255);
            w   = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            s   = 2'($urandom);
            key = k * 1024 + (a - BASE_P[k]);
            if (w && !m_mem.exists(key)) s = 2'b11;
            xact(k, w, a, d, s, t, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
